// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO pointer constants and Gray code helpers
package fifo_pkg;

  localparam int PTR_WIDTH = 11;
  localparam int DEPTH     = 1024;

  function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a Gray-coded pointer crossing clock domains
module sync_2ff #(
  parameter int width = 11
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] meta_q;
  logic [width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/r_domain.sv
// rtl/r_domain.sv - async FIFO read-domain pointers, empty flag and write-pointer synchroniser
// Occupancy and almost-empty outputs are built only when R_DOMAIN_LEVEL_EN is defined.
module r_domain
  import fifo_pkg::*;
#(
  parameter int ptr_width = PTR_WIDTH,
  parameter int depth     = DEPTH,
  parameter int ae_thresh = 4
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 ren,
  input  logic [ptr_width-1:0] r_wptr,
  output logic                 rempty,
  output logic [ptr_width-2:0] raddr,
  output logic [ptr_width-1:0] rptr,
  output logic [ptr_width-1:0] rptr_g,
  output logic                 rvalid,
  output logic [ptr_width-1:0] rlevel,
  output logic                 ralmost_empty
);

  localparam int AW = $clog2(depth);

  logic [ptr_width-1:0] wq2;
  logic [ptr_width-1:0] rptr_q, rptr_d;
  logic [ptr_width-1:0] rptr_g_q, rptr_g_d;
  logic                 rempty_q, rempty_d;
  logic                 rvalid_q, rvalid_d;
  logic                 accept;

  sync_2ff #(.width(ptr_width)) u_wptr_sync (
    .clk_i   (rclk),
    .rst_n_i (rrst_n),
    .d_i     (r_wptr),
    .q_o     (wq2)
  );

  // Empty is judged against the post-accept pointer so the last entry closes the gate at once.
  always_comb begin
    accept   = ren && !rempty_q;
    rptr_d   = rptr_q + {{(ptr_width-1){1'b0}}, accept};
    rptr_g_d = bin2gray(rptr_d);
    rempty_d = (rptr_g_d == wq2);
    rvalid_d = accept;
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rptr_q   <= '0;
      rptr_g_q <= '0;
      rempty_q <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      rptr_q   <= rptr_d;
      rptr_g_q <= rptr_g_d;
      rempty_q <= rempty_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rptr   = rptr_q;
  assign rptr_g = rptr_g_q;
  assign raddr  = rptr_q[AW-1:0];
  assign rempty = rempty_q;
  assign rvalid = rvalid_q;

`ifdef R_DOMAIN_LEVEL_EN
  logic [ptr_width-1:0] rlevel_q, rlevel_d;
  logic                 rae_q, rae_d;

  always_comb begin
    rlevel_d = gray2bin(wq2) - rptr_d;
    rae_d    = (rlevel_d <= ptr_width'(ae_thresh));
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rlevel_q <= '0;
      rae_q    <= 1'b1;
    end else begin
      rlevel_q <= rlevel_d;
      rae_q    <= rae_d;
    end
  end

  assign rlevel        = rlevel_q;
  assign ralmost_empty = rae_q;
`else
  localparam int unused_ae_thresh = ae_thresh;

  assign rlevel        = '0;
  assign ralmost_empty = rempty_q;
`endif

endmodule

// File: tb/tb_r_domain.sv
// tb/tb_r_domain.sv - self-checking bench for r_domain against a counting reference model
module tb_r_domain;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        ren;
  logic [10:0] r_wptr;
  logic        rempty;
  logic [9:0]  raddr;
  logic [10:0] rptr;
  logic [10:0] rptr_g;
  logic        rvalid;
  logic [10:0] rlevel;
  logic        ralmost_empty;

  r_domain #(.ptr_width(11), .depth(1024), .ae_thresh(4)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .ren           (ren),
    .r_wptr        (r_wptr),
    .rempty        (rempty),
    .raddr         (raddr),
    .rptr          (rptr),
    .rptr_g        (rptr_g),
    .rvalid        (rvalid),
    .rlevel        (rlevel),
    .ralmost_empty (ralmost_empty)
  );

  always #5 rclk = ~rclk;

  int total = 0;
  int bad   = 0;

  // Reference state: reads completed, write counts seen by the read side two edges late.
  int m_rd;
  int m_hist [2];
  bit m_empty;
  bit m_valid;
  int m_level;
  int wc;

  typedef struct {
    bit rstn;
    bit ren;
    int wc;
    bit e_empty;
    bit e_valid;
    int e_rptr;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [10:0] tb_gray(input int v);
    logic [10:0] b;
    b = v[10:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rempty", int'(rempty), int'(m_empty));
    chk("rvalid", int'(rvalid), int'(m_valid));
    chk("rptr", int'(rptr), m_rd);
    chk("raddr", int'(raddr), m_rd % 1024);
    chk("rptr_g", int'(rptr_g), int'(tb_gray(m_rd)));
`ifdef R_DOMAIN_LEVEL_EN
    chk("rlevel", int'(rlevel), m_level);
    chk("ralmost_empty", int'(ralmost_empty), int'(m_level <= 4));
`else
    chk("rlevel", int'(rlevel), 0);
    chk("ralmost_empty", int'(ralmost_empty), int'(m_empty));
`endif
  endtask

  task automatic tick(input bit rst_n_v, input bit ren_v, input int wcnt);
    int vis;
    bit acc;
    rrst_n = rst_n_v;
    ren    = ren_v;
    r_wptr = tb_gray(wcnt);
    @(posedge rclk);
    if (!rst_n_v) begin
      m_rd      = 0;
      m_empty   = 1'b1;
      m_valid   = 1'b0;
      m_level   = 0;
      m_hist[0] = 0;
      m_hist[1] = 0;
    end else begin
      vis       = m_hist[0];
      acc       = ren_v && !m_empty;
      m_rd      = (m_rd + int'(acc)) % 2048;
      m_valid   = acc;
      m_empty   = (vis == m_rd);
      m_level   = (vis - m_rd) & 2047;
      m_hist[0] = m_hist[1];
      m_hist[1] = wcnt & 2047;
    end
    #1;
    check_all();
  endtask

  initial begin
    int  edges;
    bit  saw_ptr_wrap;
    bit  saw_addr_wrap;
    int  prev_rptr;
    int  prev_g;
    int  prev_addr;

    rrst_n = 1'b0;
    ren    = 1'b0;
    r_wptr = '0;
    m_rd = 0; m_empty = 1'b1; m_valid = 1'b0; m_level = 0;
    m_hist[0] = 0; m_hist[1] = 0;
    wc = 0;

    tbl[0]  = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1};
    tbl[6]  = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 1};
    tbl[7]  = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 1};
    tbl[8]  = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 1};
    tbl[9]  = '{1'b1, 1'b0, 3, 1'b1, 1'b0, 1};
    tbl[10] = '{1'b1, 1'b1, 3, 1'b1, 1'b0, 1};
    tbl[11] = '{1'b1, 1'b1, 3, 1'b0, 1'b0, 1};
    tbl[12] = '{1'b1, 1'b1, 3, 1'b0, 1'b1, 2};
    tbl[13] = '{1'b1, 1'b1, 3, 1'b1, 1'b1, 3};
    tbl[14] = '{1'b1, 1'b0, 3, 1'b1, 1'b0, 3};

    @(negedge rclk);
    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].rstn, tbl[i].ren, tbl[i].wc);
      chk($sformatf("vec%0d_rempty", i), int'(rempty), int'(tbl[i].e_empty));
      chk($sformatf("vec%0d_rvalid", i), int'(rvalid), int'(tbl[i].e_valid));
      chk($sformatf("vec%0d_rptr", i), int'(rptr), tbl[i].e_rptr);
`ifdef R_DOMAIN_LEVEL_EN
      if (i == 4) chk("latency_rlevel", int'(rlevel), 1);
`endif
    end
    wc = 3;

    // Almost-empty: six more entries, then two reads.
    wc = 9;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, wc);
    chk("ae_rempty_low", int'(rempty), 0);
`ifdef R_DOMAIN_LEVEL_EN
    chk("ae_level6", int'(rlevel), 6);
    chk("ae_flag_low", int'(ralmost_empty), 0);
`endif
    tick(1'b1, 1'b1, wc);
    tick(1'b1, 1'b1, wc);
    chk("ae_rptr_after2", int'(rptr), 5);
`ifdef R_DOMAIN_LEVEL_EN
    chk("ae_level4", int'(rlevel), 4);
    chk("ae_flag_high", int'(ralmost_empty), 1);
`endif

    // Mid-operation reset with rptr=37 and write count 50.
    wc = 50;
    for (int i = 0; i < 200 && m_rd != 37; i++) tick(1'b1, 1'b1, wc);
    tick(1'b1, 1'b0, wc);
    chk("midrst_rptr37", int'(rptr), 37);
    tick(1'b0, 1'b1, wc);
    chk("midrst_rempty", int'(rempty), 1);
    chk("midrst_rptr", int'(rptr), 0);
    chk("midrst_rvalid", int'(rvalid), 0);
    chk("midrst_ae", int'(ralmost_empty), 1);
    edges = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b0, wc);
      if (!rempty) begin
        edges = i;
        break;
      end
    end
    chk("midrst_fall_edge", edges, 3);
`ifdef R_DOMAIN_LEVEL_EN
    chk("midrst_level50", int'(rlevel), 50);
`endif

    // Wrap: 2048 write/read pairs plus drain.
    saw_ptr_wrap = 1'b0;
    saw_addr_wrap = 1'b0;
    prev_rptr = int'(rptr);
    prev_g    = int'(rptr_g);
    prev_addr = int'(raddr);
    for (int k = 0; k < 2048 + 100; k++) begin
      if (k < 2048) wc++;
      tick(1'b1, 1'b1, wc);
      if (prev_rptr == 2047 && rptr == 11'd0 && prev_g == 'h400 && rptr_g == 11'd0)
        saw_ptr_wrap = 1'b1;
      if (prev_addr == 1023 && raddr == 10'd0) saw_addr_wrap = 1'b1;
      prev_rptr = int'(rptr);
      prev_g    = int'(rptr_g);
      prev_addr = int'(raddr);
    end
    chk("wrap_ptr_seen", int'(saw_ptr_wrap), 1);
    chk("wrap_addr_seen", int'(saw_addr_wrap), 1);
    chk("wrap_drained_empty", int'(rempty), 1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      if (((wc - m_rd) & 2047) < 900 && $urandom_range(0, 2) != 0) wc++;
      tick(1'b1, 1'($urandom_range(0, 1)), wc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
